// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage: state encodings,
// time limits and field widths.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_e;

   localparam int CS_MAX  = 99;
   localparam int SEC_MAX = 59;

   localparam int CENTI_W = 7;
   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// registered one-cycle press pulse on the accepted rising level.
module button_debounce #(
   parameter int DEBOUNCE_CYC = 10
) (
   input  logic clk500hz,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

   logic             sync1_q, sync2_q;
   logic             acc_q, acc_d;
   logic             acc_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk500hz) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive cycles the synchronised level disagrees with the
   // accepted level; flip the accepted level once it has held long enough.
   always_comb begin
      acc_d = acc_q;
      cnt_d = '0;
      if (sync2_q != acc_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            acc_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Stability state plus the press pulse, one cycle after the accepted rise.
   always_ff @(posedge clk500hz) begin
      if (rst) begin
         cnt_q      <= '0;
         acc_q      <= 1'b0;
         acc_prev_q <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         acc_prev_q <= acc_q;
         press_q    <= acc_q & ~acc_prev_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons drive an
// IDLE/RUN/PAUSE machine; elapsed time is kept as min:sec:centi in binary.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 10,
   parameter int TICKS_PER_CS = 5,
   parameter int MAX_MIN      = 59
) (
   input  logic               clk500hz,
   input  logic               rst,
   input  logic               btn_startstop,
   input  logic               btn_clear,
   output logic               run_on,
   output logic               pause_on,
   output logic               cs_tick,
   output logic [CENTI_W-1:0] centi,
   output logic [SEC_W-1:0]   sec,
   output logic [MIN_W-1:0]   min,
   output logic               wrap_pulse
);

   localparam int PRE_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;

   logic ss_press, clr_press;

   sw_state_e          state_q, state_d;
   logic               run_q, pause_q;
   logic [PRE_W-1:0]   presc_q, presc_d;
   logic [CENTI_W-1:0] centi_q, centi_d;
   logic [SEC_W-1:0]   sec_q, sec_d;
   logic [MIN_W-1:0]   min_q, min_d;
   logic               tick_q, tick_d;
   logic               wrap_q, wrap_d;

   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
      .clk500hz (clk500hz),
      .rst      (rst),
      .btn_i    (btn_startstop),
      .press_o  (ss_press)
   );

   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
      .clk500hz (clk500hz),
      .rst      (rst),
      .btn_i    (btn_clear),
      .press_o  (clr_press)
   );

   // Next state: clear dominates; start/stop toggles between RUN and PAUSE.
   always_comb begin
      state_d = state_q;
      if (clr_press) begin
         state_d = ST_IDLE;
      end else if (ss_press) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // State register; the mode flags decode the next state so they line up
   // with the state itself rather than trailing it by a cycle.
   always_ff @(posedge clk500hz) begin
      if (rst) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == ST_RUN);
         pause_q <= (state_d == ST_PAUSE);
      end
   end

   // Prescaler and time cascade. PAUSE holds everything, so a resume
   // finishes the partial centisecond; IDLE or a clear press zeroes it all.
   always_comb begin
      presc_d = presc_q;
      centi_d = centi_q;
      sec_d   = sec_q;
      min_d   = min_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (clr_press || state_q == ST_IDLE) begin
         presc_d = '0;
         centi_d = '0;
         sec_d   = '0;
         min_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (presc_q == PRE_W'(TICKS_PER_CS - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (centi_q == CENTI_W'(CS_MAX)) begin
               centi_d = '0;
               if (sec_q == SEC_W'(SEC_MAX)) begin
                  sec_d = '0;
                  if (min_q == MIN_W'(MAX_MIN)) begin
                     min_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     min_d = min_q + MIN_W'(1);
                  end
               end else begin
                  sec_d = sec_q + SEC_W'(1);
               end
            end else begin
               centi_d = centi_q + CENTI_W'(1);
            end
         end else begin
            presc_d = presc_q + PRE_W'(1);
         end
      end
   end

   // Time registers and the tick/wrap pulses.
   always_ff @(posedge clk500hz) begin
      if (rst) begin
         presc_q <= '0;
         centi_q <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         centi_q <= centi_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign run_on     = run_q;
   assign pause_on   = pause_q;
   assign cs_tick    = tick_q;
   assign centi      = centi_q;
   assign sec        = sec_q;
   assign min        = min_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button activity,
// compared every cycle against a behavioural model. A one-minute range
// (MAX_MIN=1) keeps the full rollover reachable in a short run.
module tb_stopwatch_ctrl;

   localparam int DB    = 10;
   localparam int TPC   = 5;
   localparam int MM    = 1;
   localparam int LIMIT = (MM + 1) * 6000;   // centiseconds per full wrap

   logic       clk500hz = 1'b0;
   logic       rst = 1'b1;
   logic       btn_startstop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       run_on, pause_on, cs_tick, wrap_pulse;
   logic [6:0] centi;
   logic [5:0] sec, min;

   stopwatch_ctrl #(.DEBOUNCE_CYC(DB), .TICKS_PER_CS(TPC), .MAX_MIN(MM)) dut (
      .clk500hz      (clk500hz),
      .rst           (rst),
      .btn_startstop (btn_startstop),
      .btn_clear     (btn_clear),
      .run_on        (run_on),
      .pause_on      (pause_on),
      .cs_tick       (cs_tick),
      .centi         (centi),
      .sec           (sec),
      .min           (min),
      .wrap_pulse    (wrap_pulse)
   );

   always #5 clk500hz = ~clk500hz;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_e;

   bit [DB+1:0] m_hist [2];   // raw samples, bit 0 newest
   bit          m_acc  [2];
   bit          m_rose [2];
   bit          m_press[2];
   mode_e       m_mode;
   int          m_presc, m_total, m_wraps;
   bit          m_tick, m_wrap;

   // One clock edge of the specified behaviour. A level is accepted once the
   // synchronised input (raw delayed by two samples) has disagreed with the
   // accepted level for DB consecutive samples.
   task model_edge();
      bit          raw[2];
      bit          ss, cl;
      bit [DB-1:0] win;
      raw[0] = btn_startstop;
      raw[1] = btn_clear;
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            m_hist[b] = '0; m_acc[b] = 0; m_rose[b] = 0; m_press[b] = 0;
         end
         m_mode = M_IDLE; m_presc = 0; m_total = 0; m_tick = 0; m_wrap = 0;
         return;
      end
      ss = m_press[0];
      cl = m_press[1];
      for (int b = 0; b < 2; b++) begin
         m_press[b] = m_rose[b];
         m_hist[b]  = {m_hist[b][DB:0], raw[b]};
         win        = m_hist[b][DB+1:2];
         m_rose[b]  = 0;
         if (m_acc[b] == 0 && &win) begin
            m_acc[b] = 1; m_rose[b] = 1;
         end else if (m_acc[b] == 1 && ~|win) begin
            m_acc[b] = 0;
         end
      end
      m_tick = 0;
      m_wrap = 0;
      if (cl) begin
         m_mode = M_IDLE; m_presc = 0; m_total = 0;
      end else begin
         if (m_mode == M_RUN) begin
            m_presc++;
            if (m_presc == TPC) begin
               m_presc = 0;
               m_tick  = 1;
               m_total = (m_total + 1) % LIMIT;
               if (m_total == 0) begin
                  m_wrap = 1; m_wraps++;
               end
            end
         end
         if (ss) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end
   endtask

   function automatic logic [31:0] pack_outs(bit r, bit p, bit t, bit w, int mi, int s, int c);
      return {9'd0, r, p, t, w, mi[5:0], s[5:0], c[6:0]};
   endfunction

   int dut_wraps = 0;

   // Advance the model on every edge and compare all outputs just after it.
   always @(posedge clk500hz) begin
      model_edge();
      #1;
      if (wrap_pulse) dut_wraps++;
      chk("outs", pack_outs(run_on, pause_on, cs_tick, wrap_pulse, min, sec, centi),
          pack_outs(m_mode == M_RUN, m_mode == M_PAUSE, m_tick, m_wrap,
                    m_total / 6000, (m_total / 100) % 60, m_total % 100));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk500hz);
   endtask

   task automatic press_ss(input int hold);
      btn_startstop = 1'b1; cyc(hold); btn_startstop = 1'b0;
   endtask

   int  ticks;
   bit  seen;
   int  len;

   initial begin
      // reset
      cyc(2);
      chk("reset_outs", pack_outs(run_on, pause_on, cs_tick, wrap_pulse, min, sec, centi), 32'd0);
      rst = 1'b0;

      // clean press: run_on rises exactly DB+4 edges after the raw rise
      btn_startstop = 1'b1;
      cyc(DB + 3);
      chk("run_before", run_on, 1'b0);
      cyc(1);
      chk("run_latency", run_on, 1'b1);
      cyc(1);
      btn_startstop = 1'b0;

      // 500 cycles of running gives exactly 100 ticks
      ticks = 0;
      for (int i = 0; i < 500; i++) begin
         cyc(1);
         if (cs_tick) ticks++;
      end
      chk("tick_count", ticks, 100);

      // bouncy press followed by a stable hold -> one transition to PAUSE
      for (int i = 0; i < 2; i++) begin
         btn_startstop = 1'b1; cyc(3);
         btn_startstop = 1'b0; cyc(3);
      end
      press_ss(15);
      cyc(20);
      chk("bounce_pause", {run_on, pause_on}, 2'b01);

      // glitches alone do nothing
      for (int i = 0; i < 3; i++) begin
         btn_startstop = 1'b1; cyc(3);
         btn_startstop = 1'b0; cyc(3);
      end
      cyc(100);
      chk("glitch_none", {run_on, pause_on}, 2'b01);

      // resume, then simultaneous start/stop and clear -> IDLE, zeroed
      press_ss(15);
      cyc(37);
      chk("resumed", {run_on, pause_on}, 2'b10);
      btn_startstop = 1'b1; btn_clear = 1'b1;
      cyc(15);
      btn_startstop = 1'b0; btn_clear = 1'b0;
      cyc(20);
      chk("clear_wins", pack_outs(run_on, pause_on, cs_tick, wrap_pulse, min, sec, centi), 32'd0);

      // clear while idle is harmless
      btn_clear = 1'b1; cyc(15); btn_clear = 1'b0; cyc(20);
      chk("clear_idle", pack_outs(run_on, pause_on, cs_tick, wrap_pulse, min, sec, centi), 32'd0);

      // random button activity with occasional resets
      for (int s = 0; s < 150; s++) begin
         len           = $urandom_range(1, 25);
         btn_startstop = 1'($urandom_range(0, 1));
         btn_clear     = ($urandom_range(0, 5) == 0);
         rst           = ($urandom_range(0, 30) == 0);
         cyc(len);
         rst = 1'b0;
      end
      btn_startstop = 1'b0; btn_clear = 1'b0;
      cyc(30);

      // reset mid-debounce: no press emerges afterwards
      btn_startstop = 1'b1; cyc(7);
      rst = 1'b1; btn_startstop = 1'b0; cyc(1);
      rst = 1'b0; cyc(30);
      chk("rst_debounce", {run_on, pause_on}, 2'b00);

      // reset mid-count: everything zero at the next edge
      press_ss(15);
      cyc(37);
      rst = 1'b1; cyc(1);
      chk("rst_count", pack_outs(run_on, pause_on, cs_tick, wrap_pulse, min, sec, centi), 32'd0);
      rst = 1'b0;

      // full rollover from zero
      press_ss(15);
      seen = 0;
      for (int i = 0; i < 61000 && !seen; i++) begin
         cyc(1);
         if (wrap_pulse) begin
            seen = 1;
            chk("wrap_time", {min, sec, centi}, 19'd0);
            chk("wrap_tick", cs_tick, 1'b1);
            chk("wrap_run", run_on, 1'b1);
         end
      end
      chk("wrap_seen", seen, 1'b1);
      cyc(1);
      chk("wrap_once", wrap_pulse, 1'b0);
      chk("wrap_still_run", run_on, 1'b1);
      chk("wrap_count", dut_wraps, m_wraps);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
